// File: rtl/if_stage_if.sv
// Bundles the fetch stage's control, program-load and IF/ID output signals.
// The slave modport is the fetch stage. The master modport is whoever drives it.
interface if_stage_if #(
    parameter int ADDR_W = 10
);
    logic              freeze;
    logic              Branch_taken;
    logic [31:0]       Branch_Address;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       PC;
    logic [31:0]       PC_out;
    logic [31:0]       Instruction;
    logic              inst_valid;

    modport master (
        output freeze, Branch_taken, Branch_Address,
        output imem_we, imem_addr, imem_wdata,
        input  PC, PC_out, Instruction, inst_valid
    );

    modport slave (
        input  freeze, Branch_taken, Branch_Address,
        input  imem_we, imem_addr, imem_wdata,
        output PC, PC_out, Instruction, inst_valid
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a
// load port, and the IF/ID pipeline register feeding decode.
module if_stage #(
    parameter int          IMEM_DEPTH = 1024,
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.slave  fetchBus
);
    logic [31:0] imem_q [IMEM_DEPTH];

    logic [31:0] pc_q, pc_d;
    logic [31:0] pcOut_q, pcOut_d;
    logic [31:0] instr_q, instr_d;
    logic        instValid_q, instValid_d;

    logic [ADDR_W-1:0] fetchIdx;
    logic [31:0]       fetchWord;

    // Low two PC bits and bits above the index are dropped, so fetch wraps.
    assign fetchIdx  = pc_q[ADDR_W+1:2];
    assign fetchWord = imem_q[fetchIdx];

    // Branch flushes even under freeze; otherwise freeze holds everything.
    always_comb begin
        pc_d        = pc_q;
        pcOut_d     = pcOut_q;
        instr_d     = instr_q;
        instValid_d = instValid_q;
        if (fetchBus.Branch_taken) begin
            pc_d        = fetchBus.Branch_Address & ~32'h0000_0003;
            pcOut_d     = 32'h0;
            instr_d     = NOP_INST;
            instValid_d = 1'b0;
        end else if (!fetchBus.freeze) begin
            pc_d        = pc_q + 32'd4;
            pcOut_d     = pc_q + 32'd4;
            instr_d     = fetchWord;
            instValid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            pcOut_q     <= 32'h0;
            instr_q     <= NOP_INST;
            instValid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pcOut_q     <= pcOut_d;
            instr_q     <= instr_d;
            instValid_q <= instValid_d;
        end
    end

    // Program load is never reset or gated; a same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (fetchBus.imem_we) begin
            imem_q[fetchBus.imem_addr] <= fetchBus.imem_wdata;
        end
    end

    assign fetchBus.PC          = pc_q;
    assign fetchBus.PC_out      = pcOut_q;
    assign fetchBus.Instruction = instr_q;
    assign fetchBus.inst_valid  = instValid_q;
endmodule
